uart_debug_rx: RTL and testbench

UART_DEBUG_RX -- requirements
Module: uart_debug_rx

---
 rtl/uart_debug_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_debug_rx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_rx.sv
// uart_debug_rx: 16-bit debug UART receiver (8N1-style framing widened to 16 data bits).
// The line is synchronised, a start bit is qualified at its centre, and 16 data
// bits are shifted in LSB first before the stop bit is checked. Completed words
// are held with a valid/ack handshake, and the receiver reports overruns and framing errors.
// Optional build macro: UART_RX_MAJORITY_EN makes every bit decision a 2-of-3 vote
// over the last three line samples. The default build uses a single sample.
module uart_debug_rx #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        rx_ack,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun
);

  localparam int HALF = BAUD_DIV / 2;
  localparam logic [8:0] HALF_LAST = 9'(HALF - 1);
  localparam logic [8:0] BIT_LAST  = 9'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic sync_meta_reg;
  logic rx_s;
  logic sample;

  state_t      state_reg, state_next;
  logic [8:0]  baud_cnt_reg, baud_cnt_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] shift_reg, shift_next;
  logic        armed_reg, armed_next;
  logic [15:0] rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        frame_err_reg, frame_err_next;
  logic        overrun_reg, overrun_next;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_reg <= 1'b1;
      rx_s          <= 1'b1;
    end else begin
      sync_meta_reg <= uart_rx;
      rx_s          <= sync_meta_reg;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_reg;

  // Keep the two previous synchronised samples so the decision cycle can vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg <= 2'b11;
    end else begin
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  // hist_reg[1] is count N-3, hist_reg[0] is N-2, and rx_s is N-1.
  assign sample = (hist_reg[1] & hist_reg[0]) |
                  (hist_reg[1] & rx_s) |
                  (hist_reg[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  // Register the state, the counters, the shift register and the output holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      baud_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      armed_reg     <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      armed_reg     <= armed_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  // Next-state logic: frame sequencing, the bit sampling and the handshake and status flags.
  always_comb begin
    state_next     = state_reg;
    baud_cnt_next  = baud_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    armed_next     = armed_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = rx_valid_reg;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    // Acknowledge consumes the held word. If a new word lands in this same cycle,
    // the DATA/STOP handling below takes priority.
    if (rx_valid_reg && rx_ack) begin
      rx_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        // armed_reg is cleared by a framing error. The receiver then waits for
        // the line to go high, so a line stuck low cannot retrigger reception.
        if (rx_s) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next    = START;
          baud_cnt_next = '0;
          bit_cnt_next  = '0;
        end
      end

      START: begin
        if (baud_cnt_reg == HALF_LAST) begin
          baud_cnt_next = '0;
          if (!sample) begin
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 9'd1;
        end
      end

      DATA: begin
        if (baud_cnt_reg == BIT_LAST) begin
          baud_cnt_next = '0;
          shift_next    = {sample, shift_reg[15:1]};
          bit_cnt_next  = bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == 5'd15) begin
            state_next = STOP;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 9'd1;
        end
      end

      STOP: begin
        if (baud_cnt_reg == BIT_LAST) begin
          baud_cnt_next = '0;
          state_next    = IDLE;
          if (sample) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            overrun_next  = rx_valid_reg && !rx_ack;
          end else begin
            frame_err_next = 1'b1;
            armed_next     = 1'b0;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 9'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_debug_rx.sv
// Testbench for uart_debug_rx. A short baud divisor keeps run time small.
// The reference model tracks the expected held word, the valid flag and the event counts at frame level.
module tb_uart_debug_rx;

  localparam int B     = 16;
  localparam int H     = B / 2;
  localparam int FRAME = 18 * B;
  // Expected start-edge-to-valid latency in clock cycles.
  localparam int LAT   = 3 + H + 17 * B;
  // Line-cycle index whose inputs are sampled by the frame-completion clock edge.
  localparam int ACK_M = LAT - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        rx_ack = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;

  uart_debug_rx #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts the cycles in which each pulse is high, and the rising edges of rx_valid.
  int   n_ferr = 0;
  int   n_ovr = 0;
  int   n_rise = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (overrun === 1'b1) n_ovr <= n_ovr + 1;
    if (rx_valid === 1'b1 && !prev_valid) begin
      n_rise   <= n_rise + 1;
      rise_cyc <= cyc;
    end
    prev_valid <= (rx_valid === 1'b1);
  end

  int compared = 0;
  int mismatched = 0;

  // Reference model state.
  logic [15:0] exp_data = 16'h0000;
  logic        exp_valid = 1'b0;
  int          exp_ferr = 0;
  int          exp_ovr = 0;
  int          exp_rise = 0;
  int          frame_c0 = 0;

  // Frame-level model: apply the outcome of one complete frame.
  task automatic model_frame(input logic [15:0] d, input logic good, input bit ack_end);
    if (good) begin
      if (exp_valid && !ack_end) exp_ovr++;
      if (!exp_valid) exp_rise++;
      exp_data  = d;
      exp_valid = 1'b1;
    end else begin
      exp_ferr++;
      if (ack_end && exp_valid) exp_valid = 1'b0;
    end
  endtask

  // Drive one frame, one line value per clock cycle. The task can stop early (stop_at),
  // invert the line for one cycle per data bit (offset from the bit centre),
  // and raise rx_ack on a single cycle.
  task automatic send_frame(input logic [15:0] d, input logic stop_bit, input int glitch_off,
                            input bit glitch_en, input int ack_m, input int stop_at);
    logic v;
    frame_c0 = cyc;
    for (int m = 0; m < stop_at; m++) begin
      if (m < B) v = 1'b0;
      else if (m < 17 * B) v = d[m / B - 1];
      else v = stop_bit;
      for (int k = 0; k < 16; k++) begin
        if (glitch_en && m == H + (k + 1) * B + glitch_off) v = ~v;
      end
      uart_rx = v;
      rx_ack  = (m == ack_m);
      @(posedge clk);
      #1;
    end
    rx_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    uart_rx = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(posedge clk);
    #1;
    rx_ack = 1'b0;
    if (exp_valid) exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (rx_data !== 16'h0000) begin mismatched++; $display("FAIL reset_data: got %h expected 0000", rx_data); end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    uart_rx = 1'b1;
    rst = 1'b0;
    idle_cycles(B);
    $display("reset: rx_data=%h rx_valid=%b", rx_data, rx_valid);
  endtask

  task automatic test_frame_error();
    send_frame(16'h1234, 1'b0, 0, 1'b0, -1, FRAME);
    model_frame(16'h1234, 1'b0, 1'b0);
    // Hold the line low well past the stop bit; the receiver must not restart.
    uart_rx = 1'b0;
    for (int i = 0; i < 3 * B; i++) begin @(posedge clk); #1; end
    idle_cycles(2 * B);
    $display("frame 1234 stop=0 -> rx_data=%h rx_valid=%b ferr_count=%0d", rx_data, rx_valid, n_ferr);
    compared++; if (n_ferr !== exp_ferr) begin mismatched++; $display("FAIL ferr_count: got %0d expected %0d", n_ferr, exp_ferr); end
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL ferr_valid: got %b expected 0", rx_valid); end
    compared++; if (rx_data !== 16'h0000) begin mismatched++; $display("FAIL ferr_data: got %h expected 0000", rx_data); end
    compared++; if (n_rise !== exp_rise) begin mismatched++; $display("FAIL ferr_rise: got %0d expected %0d", n_rise, exp_rise); end
  endtask

  task automatic test_good_frame();
    int lat;
    send_frame(16'hA5C3, 1'b1, 0, 1'b0, -1, FRAME);
    model_frame(16'hA5C3, 1'b1, 1'b0);
    lat = rise_cyc - frame_c0;
    $display("frame a5c3 stop=1 -> rx_data=%h rx_valid=%b latency=%0d", rx_data, rx_valid, lat);
    compared++; if (rx_data !== exp_data) begin mismatched++; $display("FAIL good_data: got %h expected %h", rx_data, exp_data); end
    compared++; if (rx_valid !== exp_valid) begin mismatched++; $display("FAIL good_valid: got %b expected %b", rx_valid, exp_valid); end
    compared++; if (n_rise !== exp_rise) begin mismatched++; $display("FAIL good_rise: got %0d expected %0d", n_rise, exp_rise); end
    compared++; if (lat < LAT - 1 || lat > LAT + 1) begin mismatched++; $display("FAIL good_latency: got %0d expected %0d +-1", lat, LAT); end
    compared++; if (n_ferr !== exp_ferr) begin mismatched++; $display("FAIL good_ferr: got %0d expected %0d", n_ferr, exp_ferr); end
    do_ack();
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL ack_clear: got %b expected 0", rx_valid); end
    // A second acknowledge with nothing held has no effect.
    do_ack();
    compared++; if (rx_data !== 16'hA5C3) begin mismatched++; $display("FAIL idle_ack_data: got %h expected a5c3", rx_data); end
  endtask

  task automatic test_start_glitch();
    uart_rx = 1'b0;
    for (int i = 0; i < H - 3; i++) begin @(posedge clk); #1; end
    idle_cycles(3 * B);
    $display("start glitch -> rx_valid=%b ferr_count=%0d ovr_count=%0d", rx_valid, n_ferr, n_ovr);
    compared++; if (n_rise !== exp_rise) begin mismatched++; $display("FAIL glitch_rise: got %0d expected %0d", n_rise, exp_rise); end
    compared++; if (n_ferr !== exp_ferr) begin mismatched++; $display("FAIL glitch_ferr: got %0d expected %0d", n_ferr, exp_ferr); end
    compared++; if (n_ovr !== exp_ovr) begin mismatched++; $display("FAIL glitch_ovr: got %0d expected %0d", n_ovr, exp_ovr); end
  endtask

  task automatic test_overrun();
    send_frame(16'h0001, 1'b1, 0, 1'b0, -1, FRAME);
    model_frame(16'h0001, 1'b1, 1'b0);
    send_frame(16'hFFFF, 1'b1, 0, 1'b0, -1, FRAME);
    model_frame(16'hFFFF, 1'b1, 1'b0);
    idle_cycles(4);
    $display("frames 0001,ffff -> rx_data=%h rx_valid=%b ovr_count=%0d", rx_data, rx_valid, n_ovr);
    compared++; if (n_ovr !== exp_ovr) begin mismatched++; $display("FAIL ovr_count: got %0d expected %0d", n_ovr, exp_ovr); end
    compared++; if (rx_data !== exp_data) begin mismatched++; $display("FAIL ovr_data: got %h expected %h", rx_data, exp_data); end
    compared++; if (rx_valid !== exp_valid) begin mismatched++; $display("FAIL ovr_valid: got %b expected %b", rx_valid, exp_valid); end
    do_ack();
    compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL ovr_ack: got %b expected 0", rx_valid); end
  endtask

  task automatic test_ack_same_cycle();
    send_frame(16'h1111, 1'b1, 0, 1'b0, -1, FRAME);
    model_frame(16'h1111, 1'b1, 1'b0);
    send_frame(16'h2222, 1'b1, 0, 1'b0, ACK_M, FRAME);
    model_frame(16'h2222, 1'b1, 1'b1);
    $display("frames 1111,2222 ack@end -> rx_data=%h rx_valid=%b ovr_count=%0d", rx_data, rx_valid, n_ovr);
    compared++; if (rx_data !== exp_data) begin mismatched++; $display("FAIL same_ack_data: got %h expected %h", rx_data, exp_data); end
    compared++; if (rx_valid !== exp_valid) begin mismatched++; $display("FAIL same_ack_valid: got %b expected %b", rx_valid, exp_valid); end
    compared++; if (n_ovr !== exp_ovr) begin mismatched++; $display("FAIL same_ack_ovr: got %0d expected %0d", n_ovr, exp_ovr); end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(16'hBEEF, 1'b1, 0, 1'b0, -1, 9 * B + B / 2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (rx_valid !== 1'b0 || rx_data !== 16'h0000) begin mismatched++; $display("FAIL midrst_clear: got %b/%h expected 0/0000", rx_valid, rx_data); end
    rst = 1'b0;
    exp_data  = 16'h0000;
    exp_valid = 1'b0;
    idle_cycles(2 * B);
    send_frame(16'h00FF, 1'b1, 0, 1'b0, -1, FRAME);
    model_frame(16'h00FF, 1'b1, 1'b0);
    idle_cycles(2);
    $display("frame beef aborted, 00ff -> rx_data=%h rx_valid=%b", rx_data, rx_valid);
    compared++; if (rx_data !== exp_data) begin mismatched++; $display("FAIL midrst_data: got %h expected %h", rx_data, exp_data); end
    compared++; if (n_rise !== exp_rise) begin mismatched++; $display("FAIL midrst_rise: got %0d expected %0d", n_rise, exp_rise); end
    compared++; if (n_ferr !== exp_ferr) begin mismatched++; $display("FAIL midrst_ferr: got %0d expected %0d", n_ferr, exp_ferr); end
    do_ack();
  endtask

  task automatic test_bit_glitch();
    logic [15:0] want;
    // One cycle before the bit centre: rejected in both builds.
    send_frame(16'h5A5A, 1'b1, -1, 1'b1, -1, FRAME);
    model_frame(16'h5A5A, 1'b1, 1'b0);
    $display("frame 5a5a glitch@N-2 -> rx_data=%h", rx_data);
    compared++; if (rx_data !== exp_data) begin mismatched++; $display("FAIL glitch_n2: got %h expected %h", rx_data, exp_data); end
    do_ack();
    // At the decision cycle itself: only the majority vote rejects it.
`ifdef UART_RX_MAJORITY_EN
    want = 16'h5A5A;
`else
    want = ~16'h5A5A;
`endif
    send_frame(16'h5A5A, 1'b1, 0, 1'b1, -1, FRAME);
    model_frame(want, 1'b1, 1'b0);
    $display("frame 5a5a glitch@N-1 -> rx_data=%h", rx_data);
    compared++; if (rx_data !== exp_data) begin mismatched++; $display("FAIL glitch_n1: got %h expected %h", rx_data, exp_data); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic        good;
    bit          ack_end;
    for (int i = 0; i < 12; i++) begin
      d       = 16'($urandom);
      good    = ($urandom_range(0, 4) != 0);
      ack_end = ($urandom_range(0, 3) == 0);
      send_frame(d, good, 0, 1'b0, ack_end ? ACK_M : -1, FRAME);
      model_frame(d, good, ack_end);
      if (!good) idle_cycles(4);
      if ($urandom_range(0, 1) == 1) do_ack();
      $display("frame %h stop=%b ack_end=%0d -> rx_data=%h rx_valid=%b", d, good, ack_end, rx_data, rx_valid);
      compared++; if (rx_data !== exp_data) begin mismatched++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rx_data, exp_data); end
      compared++; if (rx_valid !== exp_valid) begin mismatched++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, rx_valid, exp_valid); end
      compared++; if (n_ovr !== exp_ovr) begin mismatched++; $display("FAIL b2b_ovr[%0d]: got %0d expected %0d", i, n_ovr, exp_ovr); end
      compared++; if (n_ferr !== exp_ferr) begin mismatched++; $display("FAIL b2b_ferr[%0d]: got %0d expected %0d", i, n_ferr, exp_ferr); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame_error();
    test_good_frame();
    test_start_glitch();
    test_overrun();
    test_ack_same_cycle();
    test_reset_mid_frame();
    test_bit_glitch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
